reg_write_buffer: RTL and testbench
===================================

# reg_write_buffer

Write-side front end for the 8-bit register bank built from enable-gated flip-flop registers. Accepts addressed byte writes from the ALU/DMAC datapath, buffers them in a small FIFO, and drains them one per cycle as a one-hot register enable plus a shared data byte. Drain pauses while the bank is stalled, for example during a DMA read burst, so producers need not stall on every bank-busy cycle.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, $clog2(DEPTH+1), width of `count`

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  reset, asynchronous and active-low
- wr_req  input  1  write request from the datapath
- wr_addr  input  3  target register index, 0..7
- wr_data  input  8  byte to write
- wr_ack  output  1  combinational; `wr_req && !full`; the write is accepted at this edge
- full  output  1  registered-derived; `count == DEPTH`
- rf_stall  input  1  bank not accepting writes this cycle
- rf_en  output  8  registered one-hot enable; connects to each register's `en`
- rf_d  output  8  registered data; connects to every register's `d_in`
- count  output  CW  current FIFO occupancy
- busy  output  1  `count != 0 || rf_en != 0`
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  clears `ovf`

## Operation
- Storage: DEPTH × 11-bit entries holding {addr, data}. Read pointer `rp` and write pointer `wp` each log2(DEPTH) bits wide, wrapping modulo DEPTH.
- Push: occurs at an edge when `wr_req && !full`. Writes the entry at `wp`, then increments `wp`.
- Full is evaluated before the pop. A write arriving while `full` is rejected even if a pop happens at the same edge.
- Rejected write (`wr_req && full`): the data is dropped and `ovf` is set to 1 at that edge.
- `ovf` clears on `ovf_clr`. If set and clear happen at the same edge, set wins.
- Pop: occurs at an edge when `count != 0 && !rf_stall`.
  - `rf_en` is loaded with `1 << head.addr`; `rf_d` is loaded with `head.data`.
  - `rp` increments.
- No pop at an edge: `rf_en` is loaded with 0 and `rf_d` holds its previous value.
- `rf_en` is always either one-hot or zero. It is never high for two consecutive cycles unless two consecutive pops occur.
- Count update: +1 on push only, −1 on pop only, unchanged when push and pop happen at the same edge.
- Push and pop at the same edge when `count == 0`: the pop does not fire because `count` is 0. The new entry drains at the next edge, so there is no bypass path.
- Order is strict FIFO. Repeated writes to the same address are all issued, and the last one wins in the bank.
- Reset (asynchronous, at any time, including mid-drain):
  - `rp`, `wp`, `count` = 0
  - `rf_en` = 0, `rf_d` = 0
  - `ovf` = 0
  - Entry contents are don't-care.
  - All outputs are therefore 0 during reset: `full` = 0, `busy` = 0, `wr_ack` = 0.

## Timing
- Latency from an accepted write at edge N into an empty, unstalled FIFO:
  - `rf_en` is high between edge N+1 and edge N+2.
  - The target register captures `rf_d` at edge N+2.
- Sustained throughput is 1 write per cycle. With continuous `wr_req` and `rf_stall` = 0, `count` settles at 1.
- `rf_stall` is sampled at the pop edge only. Asserting `rf_stall` does not cancel an enable already on `rf_en`; that write completes at the next edge.
- `wr_ack` is purely combinational from `wr_req` and `full`. There is no combinational path from `rf_stall` to `wr_ack`.

## Test plan
- Reset check: assert `reset_n` = 0 mid-burst while `count` = 3 and `rf_en` = 8'h04. Required response: immediately `rf_en` = 0, `rf_d` = 0, `count` = 0, `busy` = 0, `ovf` = 0. After release, the old entries are never issued.
- Single write: write (addr 5, 8'hA7) with an empty FIFO and `rf_stall` = 0 at edge N. Required response: `wr_ack` = 1 at edge N; `rf_en` = 8'h20 and `rf_d` = 8'hA7 in the cycle after edge N+1; `rf_en` = 0 after edge N+2; `busy` falls after edge N+2.
- Fill and overflow: hold `rf_stall` = 1 and write addresses 0,1,2,3 then 4. Required response: `full` = 1 after 4 writes; the 5th write gets `wr_ack` = 0 and sets `ovf` = 1. Release `rf_stall`: `rf_en` sequence is 01, 02, 04, 08 on consecutive cycles, with data matching; addr 4 is never issued.
- Simultaneous push/pop: with `count` = 2 and no stall, issue a write every cycle for 10 cycles. Required response: `count` stays 2; the bank receives all writes in order, one per cycle.
- Stall mid-drain: with 3 entries queued, assert `rf_stall` for 2 cycles after the first pop. Required response: the first enable still completes; no `rf_en` during the stall; the remaining 2 entries issue immediately after release.
- Overflow flag: `ovf_clr` and an overflowing write at the same edge leave `ovf` = 1; `ovf_clr` alone clears it to 0.

Source files
------------

// File: rtl/reg_write_buffer.sv
// Write buffer in front of the 8-bit register bank: queues addressed byte writes
// and drains them one per unstalled cycle as a one-hot enable plus shared data byte.
module reg_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_req,
    input  logic [2:0]    wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic          full,
    input  logic          rf_stall,
    output logic [7:0]    rf_en,
    output logic [7:0]    rf_d,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic          push;
    logic          pop;
    logic [2:0]    head_addr;
    logic [7:0]    head_data;

    // Handshake: a write transfers at any rising edge where wr_req and wr_ack are
    // both high. wr_ack never waits on the bank; a request seen while full is
    // dropped (and flagged in ovf), so a producer that must not lose data holds
    // wr_req until it sees wr_ack.
    assign full   = (count == DEPTH_C);
    assign wr_ack = wr_req && !full && reset_n;
    assign busy   = (count != '0) || (rf_en != 8'h00);

    // Full is judged before the pop, so a same-edge pop never frees a slot early.
    assign push = wr_ack;
    assign pop  = (count != '0) && !rf_stall;

    assign {head_addr, head_data} = mem[rp];

    // Entry storage needs no reset; only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            rf_en <= 8'h00;
            rf_d  <= 8'h00;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end

            if (pop) begin
                rp    <= rp + AW'(1);
                rf_en <= 8'd1 << head_addr;
                rf_d  <= head_data;
            end else begin
                rf_en <= 8'h00;
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A rejected write outranks a clear at the same edge.
            if (wr_req && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the buffer and the bank interface.
module tb_reg_write_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset_n;
    logic          wr_req;
    logic [2:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic          full;
    logic          rf_stall;
    logic [7:0]    rf_en;
    logic [7:0]    rf_d;
    logic [CW-1:0] count;
    logic          busy;
    logic          ovf;
    logic          ovf_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending writes, and what the bank port should show.
    logic [10:0] exp_q[$];
    logic [7:0]  exp_en;
    logic [7:0]  exp_d;
    logic        exp_ovf;

    reg_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .full     (full),
        .rf_stall (rf_stall),
        .rf_en    (rf_en),
        .rf_d     (rf_d),
        .count    (count),
        .busy     (busy),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rf_en"}, 32'(rf_en), 32'(exp_en));
        check({tag, ".rf_d"},  32'(rf_d),  32'(exp_d));
        check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        check({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
        check({tag, ".busy"},  32'(busy),  32'((exp_q.size() != 0) || (exp_en != 8'h00)));
        check({tag, ".ovf"},   32'(ovf),   32'(exp_ovf));
    endtask

    // One clock of traffic: drive at the falling edge, model the rising edge, check after it.
    task automatic drive(input string tag, input logic req, input logic [2:0] addr,
                         input logic [7:0] data, input logic stall, input logic clr);
        logic was_full;
        logic [10:0] head;
        @(negedge clk);
        wr_req   = req;
        wr_addr  = addr;
        wr_data  = data;
        rf_stall = stall;
        ovf_clr  = clr;
        #1;
        was_full = (exp_q.size() == DEPTH);
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'(req && !was_full));
        @(posedge clk);
        if (exp_q.size() != 0 && !stall) begin
            head   = exp_q.pop_front();
            exp_en = 8'd1 << head[10:8];
            exp_d  = head[7:0];
        end else begin
            exp_en = 8'h00;
        end
        if (req && !was_full) exp_q.push_back({addr, data});
        if (req && was_full) exp_ovf = 1'b1;
        else if (clr)        exp_ovf = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic stall);
        for (int i = 0; i < n; i++) drive(tag, 1'b0, 3'd0, 8'h00, stall, 1'b0);
    endtask

    // Reset lands mid-cycle, away from any edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        wr_req   = 1'b1;
        rf_stall = 1'b0;
        ovf_clr  = 1'b0;
        reset_n  = 1'b0;
        #1;
        exp_q.delete();
        exp_en  = 8'h00;
        exp_d   = 8'h00;
        exp_ovf = 1'b0;
        check_outputs(tag);
        check({tag, ".wr_ack"}, 32'(wr_ack), 32'd0);
        @(negedge clk);
        wr_req  = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_req   = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        rf_stall = 1'b0;
        ovf_clr  = 1'b0;
        exp_en   = 8'h00;
        exp_d    = 8'h00;
        exp_ovf  = 1'b0;
        do_reset("reset0");

        // Single write: enable for exactly one cycle, one edge after acceptance.
        drive("single", 1'b1, 3'd5, 8'hA7, 1'b0, 1'b0);
        check("single.latency_count", 32'(count), 32'd1);
        drive("single", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        check("single.en_20", 32'(rf_en), 32'h20);
        idle("single", 2, 1'b0);

        // Fill while stalled, overflow with a same-edge clear, then clear alone.
        for (int i = 0; i < 4; i++) drive("fill", 1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 1'b0);
        check("fill.full", 32'(full), 32'd1);
        drive("ovf_set_wins", 1'b1, 3'd4, 8'hEE, 1'b1, 1'b1);
        idle("ovf_hold", 1, 1'b1);
        drive("ovf_clr", 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        idle("drain", 6, 1'b0);

        // Push and pop every cycle with two queued: occupancy stays put.
        for (int i = 0; i < 2; i++) drive("pre2", 1'b1, 3'(i + 6), 8'(8'h40 + i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive("stream", 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0);
        idle("stream_drain", 4, 1'b0);

        // Stall right after the first pop of three.
        for (int i = 0; i < 3; i++) drive("q3", 1'b1, 3'(i + 1), 8'(8'h70 + i), 1'b1, 1'b0);
        idle("first_pop", 1, 1'b0);
        idle("mid_stall", 2, 1'b1);
        idle("resume", 4, 1'b0);

        // Reset with three queued and rf_en = 04 in flight.
        for (int i = 0; i < 4; i++) drive("burst", 1'b1, 3'(i + 2), 8'(8'hC0 + i), 1'b1, 1'b0);
        idle("burst_pop", 1, 1'b0);
        check("burst.en_04", 32'(rf_en), 32'h04);
        do_reset("reset_mid");
        idle("after_reset", 4, 1'b0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            drive("rand", 1'($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 10));
        end
        idle("final_drain", 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
